// File: rtl/burst_arbiter_rr.sv
// Purpose : shares one W-bit streaming sink between NUM_REQ requesters, one whole burst at a time,
//           granting in round-robin order (or fixed lowest-index priority when ARB_FIXED_PRIORITY_EN is defined).
// Latency : grant and first beat can happen in the same cycle; after a burst's last beat there is one idle cycle before the next grant.
// Backpressure: beats move only while out_canReceive=1 and the owner's req_isReady=1; other requesters wait.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_start / req_numSteps      per-requester level request and burst length (length sampled in the grant cycle)
//   req_canStart                  one-hot grant pulse back to the winning requester
//   req_data / req_isReady        per-requester word and offer; only the owner's are looked at
//   req_canReceive / req_isLast   one-hot per-requester transfer enable and final-beat flag
//   out_data / out_isReady / out_isLast / out_canReceive   sink side of the muxed stream
//   grant / busy                  current owner (one-hot, 0 when idle) and burst-in-progress
module burst_arbiter_rr #(
    parameter int NUM_REQ  = 4,
    parameter int W        = 64,
    parameter int LEN_BITS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_start,
    input  logic [NUM_REQ*LEN_BITS-1:0]  req_numSteps,
    output logic [NUM_REQ-1:0]           req_canStart,
    input  logic [NUM_REQ*W-1:0]         req_data,
    input  logic [NUM_REQ-1:0]           req_isReady,
    output logic [NUM_REQ-1:0]           req_canReceive,
    output logic [NUM_REQ-1:0]           req_isLast,
    output logic [W-1:0]                 out_data,
    output logic                         out_isReady,
    input  logic                         out_canReceive,
    output logic                         out_isLast,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Registered state
    logic [LEN_BITS-1:0] cnt_q, cnt_d;      // beats still owed by the current burst
    logic [NUM_REQ-1:0]  owner_q, owner_d;  // one-hot owner of the burst in flight
    logic                hold_q, hold_d;    // idle bubble after a last beat

    // Winner of this cycle's arbitration scan
    logic [NUM_REQ-1:0]  win_oh;
    logic                win_vld;
    logic [LEN_BITS-1:0] win_steps;

    // Effective (combinational) burst view: winner in a grant cycle, registered owner otherwise
    logic [NUM_REQ-1:0]  own_oh;
    logic [LEN_BITS-1:0] counter;
    logic                idle;
    logic                arb_en;
    logic                active;
    logic                sel_rdy;
    logic                last_beat;

`ifdef ARB_FIXED_PRIORITY_EN
    // Lowest index with a pending request wins; no rotation state.
    always_comb begin
        win_oh  = '0;
        win_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_start[i] && !win_vld) begin
                win_oh[i] = 1'b1;
                win_vld   = 1'b1;
            end
        end
    end
`else
    logic [PTR_W-1:0] ptr_q, ptr_d;         // index of the most recent winner
    logic [PTR_W-1:0] win_idx;

    // Scan ptr+1, ptr+2, ... wrapping, so the last winner is looked at last.
    always_comb begin
        int               j;
        logic [PTR_W-1:0] jj;
        j       = 0;
        jj      = '0;
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jj = PTR_W'(j);
            if (req_start[jj] && !win_vld) begin
                win_oh[jj] = 1'b1;
                win_idx    = jj;
                win_vld    = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (|req_canStart) begin
            ptr_d = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PTR_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Burst length of the winner, AND-OR muxed by the one-hot.
    always_comb begin
        win_steps = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_steps = req_numSteps[i*LEN_BITS +: LEN_BITS];
            end
        end
    end

    // Arbitrate only when no burst is owed and we are not in the post-burst bubble.
    assign idle   = (cnt_q == '0);
    assign arb_en = idle && !hold_q;

    always_comb begin
        req_canStart = '0;
        own_oh       = owner_q;
        counter      = cnt_q;
        if (idle) begin
            own_oh  = '0;
            counter = '0;
            if (arb_en && win_vld) begin
                // A zero-length burst still gets its grant pulse, but counter stays 0 so nothing flows.
                req_canStart = win_oh;
                own_oh       = win_oh;
                counter      = win_steps;
            end
        end
    end

    assign active = (counter != '0);
    assign sel_rdy = |(req_isReady & own_oh);

    assign out_isReady    = active && out_canReceive && sel_rdy;
    assign last_beat      = out_isReady && (counter == LEN_BITS'(1));
    assign out_isLast     = last_beat;
    assign req_canReceive = (active && out_canReceive) ? own_oh : '0;
    assign req_isLast     = last_beat ? own_oh : '0;
    assign grant          = active ? own_oh : '0;
    assign busy           = active;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (own_oh[i]) begin
                out_data = req_data[i*W +: W];
            end
        end
    end

    // Decrement only on a real beat; a beat needs counter!=0, so no underflow.
    always_comb begin
        cnt_d   = counter;
        owner_d = owner_q;
        hold_d  = last_beat;
        if (out_isReady) begin
            cnt_d = counter - LEN_BITS'(1);
        end
        if (|req_canStart) begin
            owner_d = win_oh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            owner_q <= '0;
            hold_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_burst_arbiter_rr.sv
module tb_burst_arbiter_rr;

    localparam int NUM_REQ  = 4;
    localparam int W        = 64;
    localparam int LEN_BITS = 8;

    localparam logic [63:0] D0 = 64'hAAAA_0000_0000_0000;
    localparam logic [63:0] D1 = 64'hBBBB_1111_0000_0001;
    localparam logic [63:0] D2 = 64'hCCCC_2222_0000_0002;
    localparam logic [63:0] D3 = 64'hDDDD_3333_0000_0003;

    logic                        clk;
    logic                        rst;
    logic [NUM_REQ-1:0]          req_start;
    logic [NUM_REQ*LEN_BITS-1:0] req_numSteps;
    logic [NUM_REQ-1:0]          req_canStart;
    logic [NUM_REQ*W-1:0]        req_data;
    logic [NUM_REQ-1:0]          req_isReady;
    logic [NUM_REQ-1:0]          req_canReceive;
    logic [NUM_REQ-1:0]          req_isLast;
    logic [W-1:0]                out_data;
    logic                        out_isReady;
    logic                        out_canReceive;
    logic                        out_isLast;
    logic [NUM_REQ-1:0]          grant;
    logic                        busy;

    int checks = 0;
    int errors = 0;

    burst_arbiter_rr #(
        .NUM_REQ (NUM_REQ),
        .W       (W),
        .LEN_BITS(LEN_BITS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_start     (req_start),
        .req_numSteps  (req_numSteps),
        .req_canStart  (req_canStart),
        .req_data      (req_data),
        .req_isReady   (req_isReady),
        .req_canReceive(req_canReceive),
        .req_isLast    (req_isLast),
        .out_data      (out_data),
        .out_isReady   (out_isReady),
        .out_canReceive(out_canReceive),
        .out_isLast    (out_isLast),
        .grant         (grant),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling (well before the falling edge).
    task automatic settle();
        #2;
    endtask

    task automatic set_len(input int i, input logic [LEN_BITS-1:0] n);
        req_numSteps[i*LEN_BITS +: LEN_BITS] = n;
    endtask

    logic [NUM_REQ-1:0] exp_rr [5];

    initial begin
        rst            = 1'b1;
        req_start      = '0;
        req_numSteps   = '0;
        req_isReady    = '0;
        out_canReceive = 1'b0;
        req_data       = {D3, D2, D1, D0};

        // ---------------- reset state ----------------
        repeat (2) tick();
        rst = 1'b0;
        settle();
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_canStart", 64'(req_canStart), 64'h0);
        chk("rst_outReady", 64'(out_isReady), 64'h0);
        chk("rst_outLast", 64'(out_isLast), 64'h0);
        chk("rst_canRecv", 64'(req_canReceive), 64'h0);

        // ---------------- single requester, 3 beats ----------------
        tick();
        req_start[0]   = 1'b1;
        set_len(0, 8'd3);
        req_isReady[0] = 1'b1;
        out_canReceive = 1'b1;
        settle();
        chk("t1_c0_canStart", 64'(req_canStart), 64'h1);
        chk("t1_c0_outReady", 64'(out_isReady), 64'h1);
        chk("t1_c0_outLast", 64'(out_isLast), 64'h0);
        chk("t1_c0_grant", 64'(grant), 64'h1);
        chk("t1_c0_data", out_data, D0);
        tick();
        req_start[0] = 1'b0;
        settle();
        chk("t1_c1_outReady", 64'(out_isReady), 64'h1);
        chk("t1_c1_outLast", 64'(out_isLast), 64'h0);
        chk("t1_c1_busy", 64'(busy), 64'h1);
        tick();
        settle();
        chk("t1_c2_outReady", 64'(out_isReady), 64'h1);
        chk("t1_c2_outLast", 64'(out_isLast), 64'h1);
        chk("t1_c2_reqLast", 64'(req_isLast), 64'h1);
        tick();
        req_isReady = '0;
        settle();
        chk("t1_c3_grant", 64'(grant), 64'h0);
        chk("t1_c3_busy", 64'(busy), 64'h0);

        // ---------------- all four request, numSteps=1, from reset ----------------
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_start    = 4'b1111;
        req_isReady  = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_len(i, 8'd1);
`ifdef ARB_FIXED_PRIORITY_EN
        exp_rr = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        for (int n = 0; n < 5; n++) begin
            settle();
            chk($sformatf("t2_grant%0d_canStart", n), 64'(req_canStart), 64'(exp_rr[n]));
            chk($sformatf("t2_grant%0d_outLast", n), 64'(out_isLast), 64'h1);
            tick();
            settle();
            chk($sformatf("t2_gap%0d_canStart", n), 64'(req_canStart), 64'h0);
            tick();
        end
        req_start   = '0;
        req_isReady = '0;

        // ---------------- backpressure, requester 1, numSteps=2 ----------------
        req_start[1]   = 1'b1;
        set_len(1, 8'd2);
        req_isReady[1] = 1'b1;
        out_canReceive = 1'b0;
        settle();
        chk("t3_c0_canStart", 64'(req_canStart), 64'h2);
        chk("t3_c0_outReady", 64'(out_isReady), 64'h0);
        chk("t3_c0_canRecv", 64'(req_canReceive), 64'h0);
        tick();
        req_start[1]   = 1'b0;
        out_canReceive = 1'b1;
        settle();
        chk("t3_c1_outReady", 64'(out_isReady), 64'h1);
        chk("t3_c1_canRecv", 64'(req_canReceive), 64'h2);
        chk("t3_c1_data", out_data, D1);
        chk("t3_c1_outLast", 64'(out_isLast), 64'h0);
        tick();
        out_canReceive = 1'b0;
        settle();
        chk("t3_c2_outReady", 64'(out_isReady), 64'h0);
        chk("t3_c2_grant", 64'(grant), 64'h2);
        tick();
        out_canReceive = 1'b1;
        settle();
        chk("t3_c3_outReady", 64'(out_isReady), 64'h1);
        chk("t3_c3_outLast", 64'(out_isLast), 64'h1);
        chk("t3_c3_reqLast", 64'(req_isLast), 64'h2);
        chk("t3_c3_data", out_data, D1);
        tick();
        req_isReady = '0;
        settle();
        chk("t3_c4_grant", 64'(grant), 64'h0);
        tick();

        // ---------------- zero-length burst from requester 2 ----------------
        req_start[2]   = 1'b1;
        set_len(2, 8'd0);
        req_isReady[2] = 1'b1;
        settle();
        chk("t4_zero_canStart", 64'(req_canStart), 64'h4);
        chk("t4_zero_outReady", 64'(out_isReady), 64'h0);
        chk("t4_zero_busy", 64'(busy), 64'h0);
        chk("t4_zero_reqLast", 64'(req_isLast), 64'h0);
        tick();
        req_start      = 4'b1100;
        req_isReady    = 4'b1100;
        set_len(3, 8'd1);
        settle();
`ifdef ARB_FIXED_PRIORITY_EN
        chk("t4_next_canStart", 64'(req_canStart), 64'h4);
`else
        chk("t4_next_canStart", 64'(req_canStart), 64'h8);
        chk("t4_next_data", out_data, D3);
        chk("t4_next_outLast", 64'(out_isLast), 64'h1);
`endif
        tick();
        req_start   = '0;
        req_isReady = '0;
        tick();
        tick();

        // ---------------- non-owner isReady while requester 0 owns ----------------
        req_start      = 4'b0011;
        req_isReady    = 4'b0011;
        set_len(0, 8'd2);
        settle();
        chk("t6_c0_canStart", 64'(req_canStart), 64'h1);
        chk("t6_c0_canRecv", 64'(req_canReceive), 64'h1);
        chk("t6_c0_data", out_data, D0);
        tick();
        req_start[0] = 1'b0;
        settle();
        chk("t6_c1_canStart", 64'(req_canStart), 64'h0);
        chk("t6_c1_canRecv", 64'(req_canReceive), 64'h1);
        chk("t6_c1_data", out_data, D0);
        chk("t6_c1_outLast", 64'(out_isLast), 64'h1);
        tick();
        settle();
        chk("t6_bubble_canStart", 64'(req_canStart), 64'h0);
        chk("t6_bubble_canRecv", 64'(req_canReceive), 64'h0);
        tick();
        settle();
        chk("t6_c3_canStart", 64'(req_canStart), 64'h2);
        chk("t6_c3_data", out_data, D1);
        tick();
        req_start = '0;
        settle();
        chk("t6_c4_outLast", 64'(out_isLast), 64'h1);
        tick();
        req_isReady = '0;
        tick();

        // ---------------- reset mid-burst ----------------
        req_start[2]   = 1'b1;
        set_len(2, 8'd5);
        req_isReady[2] = 1'b1;
        settle();
        chk("t5_c0_canStart", 64'(req_canStart), 64'h4);
        tick();
        req_start[2] = 1'b0;
        settle();
        chk("t5_c1_outReady", 64'(out_isReady), 64'h1);
        tick();
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        req_isReady = '0;
        settle();
        chk("t5_after_busy", 64'(busy), 64'h0);
        chk("t5_after_grant", 64'(grant), 64'h0);
        chk("t5_after_outLast", 64'(out_isLast), 64'h0);
        req_start = 4'b1001;
        set_len(0, 8'd1);
        set_len(3, 8'd1);
        settle();
        chk("t5_rearb_canStart", 64'(req_canStart), 64'h1);
        tick();
        req_start = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
